dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port data memory between the pipeline MEMORY stage and a secondary
//  debug/loader port. Pipeline has priority; a starvation counter lets a pending debug request
//  take the memory for a short burst, stalling the MEM stage. Sits between MEMORY_STAGE and DATA_MEM.
// PARAMETERS
//  DATA_WIDTH     32  data word width
//  ADDRESS_WIDTH  32  memory address width
//  STARVE_LIMIT   4   consecutive denied debug cycles before debug gets priority (>=1)
//  DBG_BURST      2   max consecutive debug grants while in debug-priority mode (>=1)
// PORTS
//  i_CLK         in   1              clock, all state on rising edge
//  i_RST_N       in   1              asynchronous active-low reset
//  i_ALUOutM     in   ADDRESS_WIDTH  pipeline address
//  i_WriteDataM  in   DATA_WIDTH     pipeline write data
//  i_MemWriteM   in   1              pipeline write access
//  i_MemReadM    in   1              pipeline read access
//  o_ReadDataM   out  DATA_WIDTH     pipeline read data (= i_MemRData, combinational)
//  o_StallM      out  1              pipeline must hold MEM stage this cycle
//  i_DbgReq      in   1              debug request valid
//  i_DbgWe       in   1              debug write (1) / read (0)
//  i_DbgAddr     in   ADDRESS_WIDTH  debug address
//  i_DbgWData    in   DATA_WIDTH     debug write data
//  o_DbgGnt      out  1              debug request accepted this cycle
//  o_DbgRData    out  DATA_WIDTH     registered debug read data
//  o_DbgRValid   out  1              o_DbgRData valid (1-cycle pulse)
//  o_MemAddr     out  ADDRESS_WIDTH  to DATA_MEM addr
//  o_MemWData    out  DATA_WIDTH     to DATA_MEM data_in
//  o_MemWE       out  1              to DATA_MEM write_en
//  i_MemRData    in   DATA_WIDTH     from DATA_MEM data_out (combinational read)
// BEHAVIOUR
//  - pipe_acc = i_MemReadM | i_MemWriteM. States: PIPE_PRI (reset), DBG_PRI.
//  - Grant (combinational): PIPE_PRI: o_DbgGnt = i_DbgReq & ~pipe_acc. DBG_PRI: o_DbgGnt = i_DbgReq.
//  - o_StallM = o_DbgGnt & pipe_acc. Arbiter never latches pipeline inputs; held stage re-presents them.
//  - Mux: o_DbgGnt ? debug addr/wdata/(i_DbgWe) : pipeline addr/wdata/i_MemWriteM. Idle: o_MemWE=0.
//  - Handshake: transfer on i_DbgReq & o_DbgGnt at rising edge. Requester holds req/fields stable
//    until granted; deasserting an ungranted req is legal (no transfer).
//  - Read response: granted read -> o_DbgRData <= i_MemRData, o_DbgRValid=1 next cycle only.
//    Granted write -> o_DbgRValid stays 0. Back-to-back reads give back-to-back pulses.
//  - starve_cnt (saturating): +1 when i_DbgReq & ~o_DbgGnt; cleared on grant or ~i_DbgReq.
//  - PIPE_PRI -> DBG_PRI at edge where starve_cnt would reach STARVE_LIMIT; burst_cnt <= 0.
//  - DBG_PRI: each grant burst_cnt+1; -> PIPE_PRI when grant makes burst_cnt==DBG_BURST, or on
//    any cycle with ~i_DbgReq (no grant that cycle); starve_cnt cleared on exit.
//  - Grants in PIPE_PRI (pipeline idle) cause no stall, do not touch burst_cnt.
//  - Reset (any time, incl. mid-burst): state PIPE_PRI, counters 0, o_DbgRData=0, o_DbgRValid=0;
//    combinational outputs then follow PIPE_PRI rules. In-flight read response is dropped.
// STRUCTURE
//  - Shared package/include dmem_arb_defs: state encodings ARB_PIPE_PRI=1'b0, ARB_DBG_PRI=1'b1;
//    counter widths $clog2(STARVE_LIMIT+1), $clog2(DBG_BURST+1).
//  - One sub-module: sat_counter (parameterised width/max, inc, clr) used for starve_cnt and burst_cnt.
//  - Top: FSM, grant/stall logic, memory mux, response register.
// TESTING
//  1 Reset low mid-run -> o_DbgRValid=0, o_DbgRData=0, o_StallM=0, state PIPE_PRI.
//  2 Pipeline write 0xDEADBEEF @0x20 then read @0x20, no debug -> o_MemWE=1 once, o_ReadDataM=0xDEADBEEF, no stall.
//  3 Pipeline idle, debug read @0x20 -> o_DbgGnt same cycle, next cycle o_DbgRValid=1, o_DbgRData=0xDEADBEEF.
//  4 pipe_acc=1 every cycle, i_DbgReq held -> gnt=0 cycles 1-4, gnt=1 & o_StallM=1 cycles 5-6, then
//    PIPE_PRI; if req still held, next debug grant after 4 more denials (cycle 11).
//  5 In DBG_PRI after 1 grant, drop i_DbgReq -> no grant/stall that cycle, return PIPE_PRI.
//  6 Debug write 0x12345678 @0x40 during pipeline idle, then debug read @0x40 -> RValid pulse, data 0x12345678.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encoding and counter sizing.
package dmem_arb_defs;

    typedef enum logic {
        ARB_PIPE_PRI = 1'b0,
        ARB_DBG_PRI  = 1'b1
    } arb_state_e;

    // Bits needed to hold values 0..max_val; never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/dmem_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
    parameter int WIDTH = 3,
    parameter int MAX   = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MAX);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (inc && (count_reg != MAX_VAL)) begin
            count_reg <= count_reg + WIDTH'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between the MEM stage and a debug/loader port,
// with a starvation escape that lets debug steal a short burst of cycles.
module dmem_arbiter
    import dmem_arb_defs::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 32,
    parameter int STARVE_LIMIT  = 4,
    parameter int DBG_BURST     = 2
) (
    input  logic                     i_CLK,
    input  logic                     i_RST_N,
    input  logic [ADDRESS_WIDTH-1:0] i_ALUOutM,
    input  logic [DATA_WIDTH-1:0]    i_WriteDataM,
    input  logic                     i_MemWriteM,
    input  logic                     i_MemReadM,
    output logic [DATA_WIDTH-1:0]    o_ReadDataM,
    output logic                     o_StallM,
    input  logic                     i_DbgReq,
    input  logic                     i_DbgWe,
    input  logic [ADDRESS_WIDTH-1:0] i_DbgAddr,
    input  logic [DATA_WIDTH-1:0]    i_DbgWData,
    output logic                     o_DbgGnt,
    output logic [DATA_WIDTH-1:0]    o_DbgRData,
    output logic                     o_DbgRValid,
    output logic [ADDRESS_WIDTH-1:0] o_MemAddr,
    output logic [DATA_WIDTH-1:0]    o_MemWData,
    output logic                     o_MemWE,
    input  logic [DATA_WIDTH-1:0]    i_MemRData
);

    localparam int STARVE_W = cnt_width(STARVE_LIMIT);
    localparam int BURST_W  = cnt_width(DBG_BURST);
    // Values from which one more step reaches the limit.
    localparam logic [STARVE_W-1:0] STARVE_LAST = STARVE_W'(STARVE_LIMIT - 1);
    localparam logic [BURST_W-1:0]  BURST_LAST  = BURST_W'(DBG_BURST - 1);

    arb_state_e state_reg, state_next;

    logic                  pipe_acc;
    logic                  dbg_gnt;
    logic                  starve_inc, starve_clr;
    logic                  burst_inc, burst_clr;
    logic [STARVE_W-1:0]   starve_cnt;
    logic [BURST_W-1:0]    burst_cnt;
    logic [DATA_WIDTH-1:0] dbg_rdata_reg;
    logic                  dbg_rvalid_reg;

    assign pipe_acc = i_MemReadM | i_MemWriteM;

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            state_reg <= ARB_PIPE_PRI;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        dbg_gnt    = 1'b0;
        case (state_reg)
            ARB_PIPE_PRI: begin
                dbg_gnt = i_DbgReq & ~pipe_acc;
                if (i_DbgReq && !dbg_gnt && (starve_cnt == STARVE_LAST)) begin
                    state_next = ARB_DBG_PRI;
                end
            end
            ARB_DBG_PRI: begin
                dbg_gnt = i_DbgReq;
                // Leave when the burst is used up or the requester goes away.
                if (!i_DbgReq || (burst_cnt == BURST_LAST)) begin
                    state_next = ARB_PIPE_PRI;
                end
            end
            default: begin
                state_next = ARB_PIPE_PRI;
            end
        endcase
    end

    assign starve_inc = i_DbgReq & ~dbg_gnt;
    assign starve_clr = ~i_DbgReq | dbg_gnt
                      | ((state_reg == ARB_DBG_PRI) && (state_next == ARB_PIPE_PRI));
    assign burst_inc  = (state_reg == ARB_DBG_PRI) & dbg_gnt;
    assign burst_clr  = (state_reg != state_next);

    sat_counter #(
        .WIDTH (STARVE_W),
        .MAX   (STARVE_LIMIT)
    ) u_starve_cnt (
        .clk   (i_CLK),
        .rst_n (i_RST_N),
        .inc   (starve_inc),
        .clr   (starve_clr),
        .count (starve_cnt)
    );

    sat_counter #(
        .WIDTH (BURST_W),
        .MAX   (DBG_BURST)
    ) u_burst_cnt (
        .clk   (i_CLK),
        .rst_n (i_RST_N),
        .inc   (burst_inc),
        .clr   (burst_clr),
        .count (burst_cnt)
    );

    assign o_DbgGnt    = dbg_gnt;
    assign o_StallM    = dbg_gnt & pipe_acc;
    assign o_ReadDataM = i_MemRData;
    assign o_MemAddr   = dbg_gnt ? i_DbgAddr  : i_ALUOutM;
    assign o_MemWData  = dbg_gnt ? i_DbgWData : i_WriteDataM;
    assign o_MemWE     = dbg_gnt ? i_DbgWe    : i_MemWriteM;

    always_ff @(posedge i_CLK or negedge i_RST_N) begin
        if (!i_RST_N) begin
            dbg_rdata_reg  <= '0;
            dbg_rvalid_reg <= 1'b0;
        end else begin
            dbg_rvalid_reg <= dbg_gnt & ~i_DbgWe;
            if (dbg_gnt && !i_DbgWe) begin
                dbg_rdata_reg <= i_MemRData;
            end
        end
    end

    assign o_DbgRData  = dbg_rdata_reg;
    assign o_DbgRValid = dbg_rvalid_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small behavioural data memory attached.
module tb_dmem_arbiter;

    logic        clk;
    logic        rst_n;
    logic [31:0] alu_out;
    logic [31:0] pipe_wdata;
    logic        mem_write;
    logic        mem_read;
    logic [31:0] read_data;
    logic        stall;
    logic        dbg_req;
    logic        dbg_we;
    logic [31:0] dbg_addr;
    logic [31:0] dbg_wdata;
    logic        dbg_gnt;
    logic [31:0] dbg_rdata;
    logic        dbg_rvalid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic [31:0] mem_rdata;

    logic [31:0] mem [0:255];

    int n_checks;
    int n_errors;

    dmem_arbiter #(
        .DATA_WIDTH    (32),
        .ADDRESS_WIDTH (32),
        .STARVE_LIMIT  (4),
        .DBG_BURST     (2)
    ) dut (
        .i_CLK        (clk),
        .i_RST_N      (rst_n),
        .i_ALUOutM    (alu_out),
        .i_WriteDataM (pipe_wdata),
        .i_MemWriteM  (mem_write),
        .i_MemReadM   (mem_read),
        .o_ReadDataM  (read_data),
        .o_StallM     (stall),
        .i_DbgReq     (dbg_req),
        .i_DbgWe      (dbg_we),
        .i_DbgAddr    (dbg_addr),
        .i_DbgWData   (dbg_wdata),
        .o_DbgGnt     (dbg_gnt),
        .o_DbgRData   (dbg_rdata),
        .o_DbgRValid  (dbg_rvalid),
        .o_MemAddr    (mem_addr),
        .o_MemWData   (mem_wdata),
        .o_MemWE      (mem_we),
        .i_MemRData   (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word-addressed memory: combinational read, write on rising edge.
    assign mem_rdata = mem[mem_addr[9:2]];
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr[9:2]] <= mem_wdata;
    end

    task automatic check_value(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        if (observed !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end else begin
            $display("ok   %s: 0x%08h", tag, observed);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        n_checks   = 0;
        n_errors   = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        rst_n      = 1'b0;
        alu_out    = 32'h0;
        pipe_wdata = 32'h0;
        mem_write  = 1'b0;
        mem_read   = 1'b0;
        dbg_req    = 1'b0;
        dbg_we     = 1'b0;
        dbg_addr   = 32'h0;
        dbg_wdata  = 32'h0;

        repeat (2) @(posedge clk);
        sample();
        check_value("rst_rvalid", {31'h0, dbg_rvalid}, 32'h0);
        check_value("rst_rdata", dbg_rdata, 32'h0);
        check_value("rst_stall", {31'h0, stall}, 32'h0);
        step();
        rst_n = 1'b1;

        // Pipeline write then read, no debug traffic
        step();
        mem_write = 1'b1; alu_out = 32'h20; pipe_wdata = 32'hDEADBEEF;
        sample();
        check_value("pw_we", {31'h0, mem_we}, 32'h1);
        check_value("pw_addr", mem_addr, 32'h20);
        check_value("pw_stall", {31'h0, stall}, 32'h0);
        step();
        mem_write = 1'b0; mem_read = 1'b1;
        sample();
        check_value("pr_we", {31'h0, mem_we}, 32'h0);
        check_value("pr_data", read_data, 32'hDEADBEEF);
        check_value("pr_stall", {31'h0, stall}, 32'h0);

        // Debug read while pipeline idle
        step();
        mem_read = 1'b0;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h20;
        sample();
        check_value("dr_gnt", {31'h0, dbg_gnt}, 32'h1);
        check_value("dr_stall", {31'h0, stall}, 32'h0);
        step();
        dbg_req = 1'b0;
        sample();
        check_value("dr_rvalid", {31'h0, dbg_rvalid}, 32'h1);
        check_value("dr_rdata", dbg_rdata, 32'hDEADBEEF);
        step();
        sample();
        check_value("dr_rvalid_end", {31'h0, dbg_rvalid}, 32'h0);

        // Debug write then debug read of the same word
        step();
        dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h40; dbg_wdata = 32'h12345678;
        sample();
        check_value("dw_gnt", {31'h0, dbg_gnt}, 32'h1);
        check_value("dw_we", {31'h0, mem_we}, 32'h1);
        step();
        dbg_we = 1'b0;
        sample();
        check_value("dw_no_rvalid", {31'h0, dbg_rvalid}, 32'h0);
        check_value("dw_rd_gnt", {31'h0, dbg_gnt}, 32'h1);
        step();
        dbg_req = 1'b0;
        sample();
        check_value("dw_rd_rvalid", {31'h0, dbg_rvalid}, 32'h1);
        check_value("dw_rd_rdata", dbg_rdata, 32'h12345678);

        // Starvation: pipeline busy every cycle, debug read held
        step();
        mem_read = 1'b1; alu_out = 32'h20;
        dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 32'h40;
        for (int c = 1; c <= 11; c++) begin
            logic exp_gnt;
            logic exp_rv;
            exp_gnt = (c == 5) || (c == 6) || (c == 11);
            exp_rv  = (c == 6) || (c == 7);
            sample();
            check_value($sformatf("st_gnt_c%0d", c), {31'h0, dbg_gnt}, {31'h0, exp_gnt});
            check_value($sformatf("st_stall_c%0d", c), {31'h0, stall}, {31'h0, exp_gnt});
            check_value($sformatf("st_rvalid_c%0d", c), {31'h0, dbg_rvalid}, {31'h0, exp_rv});
            if (exp_gnt) check_value($sformatf("st_addr_c%0d", c), mem_addr, 32'h40);
            step();
        end

        // Drop request while in debug priority after one grant
        dbg_req = 1'b0;
        sample();
        check_value("drop_gnt", {31'h0, dbg_gnt}, 32'h0);
        check_value("drop_stall", {31'h0, stall}, 32'h0);
        check_value("drop_rvalid", {31'h0, dbg_rvalid}, 32'h1);
        check_value("drop_rdata", dbg_rdata, 32'h12345678);
        step();
        dbg_req = 1'b1;
        // Back in pipeline priority: four denials, then a grant
        for (int c = 13; c <= 17; c++) begin
            sample();
            check_value($sformatf("re_gnt_c%0d", c), {31'h0, dbg_gnt}, {31'h0, (c == 17)});
            if (c != 17) step();
        end

        // Asynchronous reset during a granted debug read
        #2;
        rst_n = 1'b0;
        #1;
        check_value("mrst_gnt", {31'h0, dbg_gnt}, 32'h0);
        check_value("mrst_stall", {31'h0, stall}, 32'h0);
        check_value("mrst_rdata", dbg_rdata, 32'h0);
        @(posedge clk);
        sample();
        check_value("mrst_rvalid", {31'h0, dbg_rvalid}, 32'h0);
        check_value("mrst_rdata2", dbg_rdata, 32'h0);
        step();
        rst_n = 1'b1;
        sample();
        check_value("post_rst_gnt", {31'h0, dbg_gnt}, 32'h0);
        check_value("post_rst_stall", {31'h0, stall}, 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
